// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory request/response port between the instruction fetch
//   unit (read-only) and the load/store unit (read/write). Only one
//   transaction is in flight at a time. The arbiter registers the request
//   toward memory and routes the response back to the master that owns it.
//   When both masters request together, grants alternate round-robin.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ifu_req_* / ifu_addr     IFU request channel (valid/ready)
//   ifu_resp_* / ifu_rdata   IFU response channel
//   lsu_req_* / lsu_addr,    LSU request channel
//     lsu_wen/wdata/wmask
//   lsu_resp_* / lsu_rdata   LSU response channel
//   mem_req_* / mem_addr,    registered request toward memory
//     mem_wen/wdata/wmask
//   mem_resp_* / mem_rdata   memory response channel
//   owner                    current/last owner (0 = IFU, 1 = LSU)
//   busy                     transaction in flight (state != IDLE)
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                owner,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SREQ  = 2'd1,
    SRESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;  // 0 = IFU, 1 = LSU
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;

  // Per-master vectors, index 0 = IFU, index 1 = LSU.
  logic [1:0]          req_vec;
  logic [1:0]          grant_vec;
  logic [1:0]          resp_ready_vec;
  logic [1:0]          resp_valid_vec;
  logic [DATA_W-1:0]   rdata_vec [2];

  logic                resp_phase;
  logic                resp_hs;

  assign req_vec        = {lsu_req_valid, ifu_req_valid};
  assign resp_ready_vec = {lsu_resp_ready, ifu_resp_ready};

  // Every handshake output is masked while rst is high, even though the
  // state register only clears on the next edge.
  assign resp_phase = (state_q == SRESP) && !rst;

  // Grant: sole requester wins; on a tie the master not granted last wins.
  always_comb begin
    grant_vec = 2'b00;
    if (state_q == IDLE && !rst) begin
      case (req_vec)
        2'b01:   grant_vec = 2'b01;
        2'b10:   grant_vec = 2'b10;
        2'b11:   grant_vec = last_grant_q ? 2'b01 : 2'b10;
        default: grant_vec = 2'b00;
      endcase
    end
  end

  // Response routing: only the owner sees the memory response.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      localparam logic SEL = 1'(gi);
      assign resp_valid_vec[gi] = resp_phase && (owner_q == SEL) && mem_resp_valid;
      assign rdata_vec[gi]      = (resp_phase && (owner_q == SEL)) ? mem_rdata : '0;
    end
  endgenerate

  assign mem_resp_ready = resp_phase && resp_ready_vec[owner_q];
  assign resp_hs        = mem_resp_valid && mem_resp_ready;

  assign ifu_req_ready  = grant_vec[0];
  assign lsu_req_ready  = grant_vec[1];
  assign ifu_resp_valid = resp_valid_vec[0];
  assign lsu_resp_valid = resp_valid_vec[1];
  assign ifu_rdata      = rdata_vec[0];
  assign lsu_rdata      = rdata_vec[1];

  assign mem_req_valid  = (state_q == SREQ) && !rst;
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign owner          = owner_q;
  assign busy           = (state_q != IDLE);

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;

    case (state_q)
      IDLE: begin
        if (grant_vec != 2'b00) begin
          state_d = SREQ;
          owner_d = grant_vec[1];
          if (grant_vec[1]) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
          end else begin
            // Fetches are always reads with an empty mask.
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      SREQ: begin
        if (mem_req_valid && mem_req_ready) begin
          state_d = SRESP;
        end
      end
      SRESP: begin
        if (resp_hs) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
          // Payload returns to zero so the memory side is quiet when idle.
          addr_d       = '0;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;  // first tie after reset goes to the IFU
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory request/response port between the instruction fetch unit (read-only master) and the load/store unit (read/write master) in the multicycle core.
- Accepts one transaction at a time and registers it toward memory.
- Routes the response back only to the master that owns the transaction.
- Grants round-robin when both masters request in the same cycle.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; write mask width is DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  reset
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  fetch data valid
ifu_resp_ready  in  1  IFU can take response
ifu_rdata  out  DATA_W  fetched instruction
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  load/store address
lsu_wen  in  1  1 = store, 0 = load
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  byte enables
lsu_resp_valid  out  1  load data / store done
lsu_resp_ready  in  1  LSU can take response
lsu_rdata  out  DATA_W  load data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  registered address
mem_wen  out  1  registered write enable
mem_wdata  out  DATA_W  registered write data
mem_wmask  out  DATA_W/8  registered mask
mem_resp_valid  in  1  memory response
mem_resp_ready  out  1  response accepted
mem_rdata  in  DATA_W  memory read data
owner  out  1  current/last owner, 0 = IFU, 1 = LSU
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Valid/ready rule on all channels: a transfer occurs on a clk edge where valid & ready are both 1. Masters hold valid and payload stable until accepted.
- States are IDLE, SREQ and SRESP. Reset puts the state in IDLE.
- IDLE:
  - If exactly one master has req_valid, it wins.
  - If both do, the master that is not last_grant wins.
  - last_grant resets to LSU, so the first tie goes to IFU.
  - The winner's req_ready = 1 combinationally in the same cycle. The loser's req_ready = 0.
  - On that edge the arbiter latches addr, wen, wdata and wmask. For an IFU grant, wen = 0, wmask = 0 and wdata = 0.
  - owner <= winner. Next state is SREQ.
  - With no request, state stays IDLE and all outputs are 0.
- SREQ:
  - mem_req_valid = 1 from the latched registers.
  - On mem_req_ready, go to SRESP. Otherwise hold; the payload must not change.
- SRESP:
  - owner's resp_valid = mem_resp_valid, and owner's rdata = mem_rdata (combinational pass-through).
  - mem_resp_ready = owner's resp_ready.
  - On the mem_resp_valid & resp_ready handshake, set last_grant <= owner and go to IDLE.
  - The non-owner's resp_valid = 0 and rdata = 0.
- Latency from master req_valid to mem_req_valid is 1 cycle. The response path adds zero cycles.
- A new request from either master is accepted no earlier than the cycle after the response handshake (the IDLE cycle). Exactly one transaction is outstanding.
- All req_ready are 0 in SREQ and SRESP. A master raising req_valid mid-transaction waits and keeps its request.
- A request arriving in the same cycle as the response handshake is seen in the following IDLE cycle.
- mem_resp_valid outside SRESP is ignored: no master sees it, and mem_resp_ready = 0.
- rst asserted in any state:
  - Next state IDLE, registers cleared, last_grant = LSU.
  - While rst = 1, every ready/valid output is 0, even in IDLE with a request pending.
  - An in-flight transaction is dropped.
- Reset values: mem_addr, mem_wdata, mem_wmask, mem_wen, owner, busy, every valid and every ready are all 0.

Test Plan:
- IFU only: ifu_addr=0x80000000, memory returns 0x00000413 after 2 cycles.
  - Required: ifu_req_ready for 1 cycle; mem_req_valid the next cycle with mem_addr=0x80000000 and mem_wen=0; ifu_resp_valid with ifu_rdata=0x00000413; lsu_resp_valid stays 0.
- Simultaneous requests after reset: IFU addr 0x80000004, LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF.
  - Required: IFU is granted first. After its response, the LSU is granted in the next IDLE, with mem_wen=1 and mem_wmask=0xF.
- Repeated contention: both masters hold req_valid for 4 transactions.
  - Required: grant order is IFU, LSU, IFU, LSU, and busy drops for exactly 1 cycle between transactions.
- Backpressure:
  - mem_req_ready=0 for 5 cycles: mem_addr/wdata stay constant and no master is accepted.
  - lsu_resp_ready=0 for 3 cycles with mem_resp_valid=1: mem_resp_ready=0, and the handshake happens on the first cycle lsu_resp_ready=1.
- Reset mid-transaction: assert rst in SRESP.
  - Required: next cycle busy=0, all valids 0. The next tie grants IFU.
- Stray response: pulse mem_resp_valid in IDLE.
  - Required: no resp_valid to either master, and state stays IDLE.
